// File: rtl/fifo_rd_seq_checker_if.sv
// Read port of the 16->32 FWFT FIFO: head word, valid, and the pop request.
// master = FIFO side, slave = consumer side.
interface fifo_rd_seq_checker_if #(
   parameter int HALF_WIDTH = 16
);
   logic [2*HALF_WIDTH-1:0] rdata;
   logic                    rd_valid;
   logic                    rd_en;

   modport master (output rdata, output rd_valid, input rd_en);
   modport slave  (input rdata, input rd_valid, output rd_en);
endinterface

// File: rtl/fifo_rd_seq_checker.sv
// Pops the FWFT FIFO once armed by prog_full and checks the writer's incrementing pattern; err_o sticky.
// Latency: err_o 1 cycle after a bad pop; rd_en combinational from regs, paused by stop_i/THROTTLE. Stats: FIFO_RD_CHK_STATS_EN.
module fifo_rd_seq_checker #(
   parameter int HALF_WIDTH    = 16,
   parameter int THROTTLE      = 0
`ifdef FIFO_RD_CHK_STATS_EN
   ,
   parameter int ERR_CNT_WIDTH = 16
`endif
) (
   input  logic                 rd_clk_i,
   input  logic                 a_rst_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 trigger_i,
   fifo_rd_seq_checker_if.slave rd,
   output logic                 synced_o,
   output logic                 err_o
`ifdef FIFO_RD_CHK_STATS_EN
   ,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
   output logic [31:0]              word_cnt_o
`endif
);
   localparam int THR_W = (THROTTLE < 1) ? 1 : $clog2(THROTTLE + 1);
   localparam logic [HALF_WIDTH-1:0] ONE = HALF_WIDTH'(1);
   localparam logic [HALF_WIDTH-1:0] TWO = HALF_WIDTH'(2);

   typedef enum logic [1:0] {IDLE, ARM, SYNC, RUN} state_t;

   state_t                state;
   logic [HALF_WIDTH-1:0] exp_val;
   logic [HALF_WIDTH-1:0] upper;
   logic [HALF_WIDTH-1:0] lower;
   logic [THR_W-1:0]      thr_cnt;
   logic                  pop;
   logic                  mismatch;

   // upper half holds the earlier write-side sample
   assign upper    = rd.rdata[2*HALF_WIDTH-1:HALF_WIDTH];
   assign lower    = rd.rdata[HALF_WIDTH-1:0];
   assign rd.rd_en = ((state == SYNC) || (state == RUN)) && !stop_i && (thr_cnt == '0);
   assign pop      = rd.rd_en && rd.rd_valid;

   always_comb begin
      mismatch = 1'b0;
      if (state == SYNC)
         mismatch = (lower != upper + ONE);
      else
         mismatch = (upper != exp_val) || (lower != exp_val + ONE);
   end

   always_ff @(posedge rd_clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         state    <= IDLE;
         synced_o <= 1'b0;
         err_o    <= 1'b0;
         exp_val  <= '0;
         thr_cnt  <= '0;
      end else begin
         if (pop) begin
            thr_cnt <= THR_W'(THROTTLE);
            // re-seed from the received word so one bad word flags once, not forever
            exp_val <= mismatch ? upper + TWO : exp_val + TWO;
            if (state == SYNC)
               exp_val <= upper + TWO;
            if (mismatch)
               err_o <= 1'b1;
         end else if ((thr_cnt != '0) && !stop_i) begin
            thr_cnt <= thr_cnt - THR_W'(1);
         end

         case (state)
            IDLE: if (start_i) state <= ARM;
            ARM:  if (trigger_i) state <= SYNC;
            SYNC: if (pop) begin
               state    <= RUN;
               synced_o <= 1'b1;
            end
            default: ;
         endcase

         if (!start_i) begin
            state    <= IDLE;
            synced_o <= 1'b0;
         end
      end
   end

`ifdef FIFO_RD_CHK_STATS_EN
   always_ff @(posedge rd_clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         err_cnt_o  <= '0;
         word_cnt_o <= '0;
      end else if (pop) begin
         word_cnt_o <= word_cnt_o + 32'd1;
         if (mismatch && (err_cnt_o != '1))
            err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
      end
   end
`endif
endmodule

// File: tb/tb_fifo_rd_seq_checker.sv
// Bench: dut0 (THROTTLE=0) runs the sequence/wrap/error/restart/reset cases through a scoreboard;
// dut1 (THROTTLE=3) fed by an endless correct source covers pop pacing and stop_i.
module tb_fifo_rd_seq_checker;
   localparam int W = 16;

   typedef struct packed {
      logic err;
      logic synced;
   } exp_t;

   logic rd_clk = 1'b0;
   logic a_rst  = 1'b0;
   logic start0 = 1'b0, stop0 = 1'b0, trig0 = 1'b0, synced0, err0;
   logic start1 = 1'b0, stop1 = 1'b0, trig1 = 1'b0, synced1, err1;
`ifdef FIFO_RD_CHK_STATS_EN
   logic [15:0] err_cnt0, err_cnt1;
   logic [31:0] word_cnt0, word_cnt1;
`endif

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] fq[$];
   exp_t        sbq[$];
   logic [15:0] c1 = 16'h0001;

   fifo_rd_seq_checker_if #(.HALF_WIDTH(W)) rd0 ();
   fifo_rd_seq_checker_if #(.HALF_WIDTH(W)) rd1 ();

   always #5 rd_clk = ~rd_clk;

   fifo_rd_seq_checker #(.HALF_WIDTH(W), .THROTTLE(0)) dut0 (
      .rd_clk_i  (rd_clk),
      .a_rst_i   (a_rst),
      .start_i   (start0),
      .stop_i    (stop0),
      .trigger_i (trig0),
      .rd        (rd0),
      .synced_o  (synced0),
      .err_o     (err0)
`ifdef FIFO_RD_CHK_STATS_EN
      ,
      .err_cnt_o (err_cnt0),
      .word_cnt_o(word_cnt0)
`endif
   );

   fifo_rd_seq_checker #(.HALF_WIDTH(W), .THROTTLE(3)) dut1 (
      .rd_clk_i  (rd_clk),
      .a_rst_i   (a_rst),
      .start_i   (start1),
      .stop_i    (stop1),
      .trigger_i (trig1),
      .rd        (rd1),
      .synced_o  (synced1),
      .err_o     (err1)
`ifdef FIFO_RD_CHK_STATS_EN
      ,
      .err_cnt_o (err_cnt1),
      .word_cnt_o(word_cnt1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge rd_clk);
      #1;
   endtask

   task automatic feed(input logic [31:0] w, input logic e);
      fq.push_back(w);
      sbq.push_back({e, 1'b1});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fq.size() != 0 || sbq.size() != 0) && n < 2000) begin
         @(posedge rd_clk);
         #1;
         n++;
      end
      chk("drain_pending", 32'(fq.size() + sbq.size()), 0);
   endtask

   task automatic arm0();
      start0 = 1'b1;
      tick(2);
      trig0 = 1'b1;
      tick(1);
      trig0 = 1'b0;
   endtask

   // FIFO model for dut0: head word held until a pop is seen
   initial begin
      logic p;
      rd0.rdata    = '0;
      rd0.rd_valid = 1'b0;
      forever begin
         @(negedge rd_clk);
         p = rd0.rd_en && rd0.rd_valid;
         @(posedge rd_clk);
         #1;
         if (p && fq.size() != 0) void'(fq.pop_front());
         rd0.rd_valid = (fq.size() != 0);
         rd0.rdata    = (fq.size() != 0) ? fq[0] : '0;
      end
   end

   // endless correct source for dut1
   initial begin
      logic p;
      rd1.rd_valid = 1'b1;
      rd1.rdata    = {16'h0001, 16'h0002};
      forever begin
         @(negedge rd_clk);
         p = rd1.rd_en && rd1.rd_valid;
         @(posedge rd_clk);
         #1;
         if (p) c1 = c1 + 16'h0002;
         rd1.rdata = {c1, c1 + 16'h0001};
      end
   end

   // scoreboard monitor: compare flags one cycle after each observed pop
   initial begin
      logic pend;
      exp_t e;
      pend = 1'b0;
      forever begin
         @(negedge rd_clk);
         if (pend) begin
            chk("sb_entry_present", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               chk("sb_err", err0, e.err);
               chk("sb_synced", synced0, e.synced);
            end
         end
         pend = rd0.rd_en && rd0.rd_valid;
      end
   end

   initial begin
      int n;
      int prev;
      logic [15:0] c1_hold;

      #1 a_rst = 1'b1;
      tick(2);
      chk("rst_rd_en", rd0.rd_en, 0);
      chk("rst_synced", synced0, 0);
      chk("rst_err", err0, 0);
      chk("rst_rd_en_dut1", rd1.rd_en, 0);
      a_rst = 1'b0;
      tick(1);

      // incrementing stream of 100 words
      start0 = 1'b1;
      tick(2);
      chk("arm_rd_en", rd0.rd_en, 0);
      trig0 = 1'b1;
      tick(1);
      trig0 = 1'b0;
      chk("sync_rd_en", rd0.rd_en, 1);
      chk("sync_not_synced", synced0, 0);
      for (int k = 0; k < 100; k++)
         feed({16'(2 * k + 1), 16'(2 * k + 2)}, 1'b0);
      drain();
      chk("t1_synced", synced0, 1);
      chk("t1_err", err0, 0);
`ifdef FIFO_RD_CHK_STATS_EN
      chk("t1_word_cnt", word_cnt0, 100);
`endif

      // start drop and restart from the beginning of the sequence
      start0 = 1'b0;
      tick(1);
      chk("stop_rd_en", rd0.rd_en, 0);
      chk("stop_synced", synced0, 0);
      chk("stop_err", err0, 0);
      arm0();
      feed({16'h0001, 16'h0002}, 1'b0);
      feed({16'h0003, 16'h0004}, 1'b0);
      feed({16'h0005, 16'h0006}, 1'b0);
      feed({16'h0007, 16'h0008}, 1'b0);
      drain();
      chk("t5_err", err0, 0);

      // wrap through FFFF -> 0000
      start0 = 1'b0;
      tick(1);
      arm0();
      feed({16'hFFF9, 16'hFFFA}, 1'b0);
      feed({16'hFFFB, 16'hFFFC}, 1'b0);
      feed({16'hFFFD, 16'hFFFE}, 1'b0);
      feed({16'hFFFF, 16'h0000}, 1'b0);
      feed({16'h0001, 16'h0002}, 1'b0);
      feed({16'h0003, 16'h0004}, 1'b0);
      drain();
      chk("wrap_err", err0, 0);

      // 10th word corrupted, stream resyncs afterwards
      start0 = 1'b0;
      tick(1);
      arm0();
      for (int k = 0; k < 9; k++)
         feed({16'(2 * k + 1), 16'(2 * k + 2)}, 1'b0);
      feed({16'h0013, 16'h0015}, 1'b1);
      feed({16'h0015, 16'h0016}, 1'b1);
      feed({16'h0017, 16'h0018}, 1'b1);
      drain();
      chk("corrupt_err_sticky", err0, 1);
`ifdef FIFO_RD_CHK_STATS_EN
      chk("corrupt_err_cnt", err_cnt0, 1);
      chk("total_word_cnt", word_cnt0, 122);
`endif

      // throttled consumer: one pop every 4 cycles, stop_i pause
      start1 = 1'b1;
      tick(2);
      trig1 = 1'b1;
      tick(1);
      trig1 = 1'b0;
      n = 0;
      prev = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge rd_clk);
         if (rd1.rd_en) begin
            if (prev >= 0) chk("throttle_gap", 32'(i - prev), 4);
            prev = i;
            n++;
         end
      end
      chk("throttle_count", 32'(n), 4);
      @(posedge rd_clk);
      #1;
      stop1   = 1'b1;
      c1_hold = c1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge rd_clk);
         if (rd1.rd_en) n++;
      end
      chk("stop_rd_en_count", 32'(n), 0);
      chk("stop_no_pop", c1, c1_hold);
      @(posedge rd_clk);
      #1;
      stop1 = 1'b0;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge rd_clk);
         if (rd1.rd_en) n++;
      end
      chk("resume_count", 32'(n), 4);
      chk("throttle_err", err1, 0);
      chk("throttle_synced", synced1, 1);

      // async reset while rd_en is high
      start0 = 1'b0;
      tick(1);
      arm0();
      feed({16'h0001, 16'h0002}, 1'b1);
      drain();
      chk("pre_rst_rd_en", rd0.rd_en, 1);
      chk("pre_rst_synced", synced0, 1);
      @(negedge rd_clk);
      #2 a_rst = 1'b1;
      #1;
      chk("async_rst_rd_en", rd0.rd_en, 0);
      chk("async_rst_err", err0, 0);
      chk("async_rst_synced", synced0, 0);
`ifdef FIFO_RD_CHK_STATS_EN
      chk("async_rst_err_cnt", err_cnt0, 0);
      chk("async_rst_word_cnt", word_cnt0, 0);
`endif
      tick(2);
      a_rst = 1'b0;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
